// File: rtl/heightmap_renderer.sv
// Isometric heightmap renderer: inverse-projects each VGA pixel onto a
// double-buffered height grid and emits a shaded or grid-line colour 3 clocks later.
module heightmap_renderer #(
  parameter int          MAP_DIM     = 16,
  parameter int          H_W         = 8,
  parameter int          CELL_SHIFT  = 3,
  parameter int          ORIGIN_X    = 320,
  parameter int          ORIGIN_Y    = 40,
  parameter int          INIT_HEIGHT = 50,
  parameter logic [23:0] LINE_BGR    = 24'hFFFFFF,
  parameter logic [23:0] BG_BGR      = 24'h000000,
  localparam int         AW          = $clog2(MAP_DIM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            draw_area,
  input  logic [9:0]      xpos,
  input  logic [9:0]      ypos,
  input  logic            frame_start,
  input  logic            wr_en,
  input  logic [2*AW-1:0] wr_addr,
  input  logic [H_W-1:0]  wr_data,
  input  logic            wr_commit,
  output logic [23:0]     bgr24,
  output logic            out_valid,
  output logic            swap_pending,
  output logic            active_bank
);

  localparam int DEPTH = 2 * MAP_DIM * MAP_DIM;

  typedef enum logic {IDLE, PENDING} swap_state_t;

  swap_state_t state, state_next;
  logic        do_swap;

  always_comb begin
    state_next = state;
    do_swap    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_commit && frame_start) do_swap = 1'b1;
        else if (wr_commit)           state_next = PENDING;
      end
      PENDING: begin
        if (frame_start) begin
          do_swap    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      active_bank <= 1'b0;
    end else begin
      state <= state_next;
      if (do_swap) active_bank <= ~active_bank;
    end
  end

  assign swap_pending = (state == PENDING);

  // Stage 1: screen offset to rotated isometric coordinates
  logic signed [11:0] dx, dy;
  logic        [12:0] p_next, q_next;
  logic signed [12:0] p_q, q_q;
  logic               v1;

  assign dx     = $signed({2'b00, xpos}) - $signed(12'(ORIGIN_X));
  assign dy     = $signed({2'b00, ypos}) - $signed(12'(ORIGIN_Y));
  assign p_next = {dy, 1'b0} + {dx[11], dx};
  assign q_next = {dy, 1'b0} - {dx[11], dx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      p_q <= '0;
      q_q <= '0;
    end else begin
      v1  <= draw_area;
      p_q <= $signed(p_next);
      q_q <= $signed(q_next);
    end
  end

  // Stage 2: cell lookup; out-of-range cells show as zero upper bits failing
  logic signed [12:0] mx_full, my_full;
  logic               inside_c, grid_c;
  logic [2*AW:0]      rd_addr;
  logic               v2, inside_q, grid_q;
  logic [H_W-1:0]     h_q;
  logic [H_W-1:0]     mem [DEPTH] = '{default: H_W'(INIT_HEIGHT)};

  assign mx_full  = p_q >>> (CELL_SHIFT + 1);
  assign my_full  = q_q >>> (CELL_SHIFT + 1);
  assign inside_c = v1 && (mx_full[12:AW] == '0) && (my_full[12:AW] == '0);
  assign grid_c   = (p_q[CELL_SHIFT:0] == '0) || (q_q[CELL_SHIFT:0] == '0);
  assign rd_addr  = {active_bank, my_full[AW-1:0], mx_full[AW-1:0]};

  // The shadow bank is chosen before any same-cycle swap takes effect
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~active_bank, wr_addr}] <= wr_data;
    h_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      inside_q <= 1'b0;
      grid_q   <= 1'b0;
    end else begin
      v2       <= v1;
      inside_q <= inside_c;
      grid_q   <= grid_c;
    end
  end

  // Stage 3: colour select
  logic [7:0] shade_g, shade_r;

  assign shade_g = 8'(h_q);
  assign shade_r = 8'(h_q >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bgr24     <= BG_BGR;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v2;
      if (!inside_q)   bgr24 <= BG_BGR;
      else if (grid_q) bgr24 <= LINE_BGR;
      else             bgr24 <= {8'd0, shade_g, shade_r};
    end
  end

endmodule
